// File: rtl/traffic_ctrl_2way.sv
// traffic_ctrl_2way: two-way intersection controller (main road / side road)
// with a countdown of the remaining ticks shown as BCD and on two 7-segment digits.
// The optional pedestrian walk phase is built only when TRAFFIC_PED_EN is defined.
// Without TRAFFIC_PED_EN, ped_req is ignored and walk is held low.
module traffic_ctrl_2way #(
    parameter int unsigned TICK_DIV     = 50000000,
    parameter int unsigned MAIN_GREEN_S = 16,
    parameter int unsigned SIDE_GREEN_S = 10,
    parameter int unsigned YELLOW_S     = 5,
    parameter int unsigned ALLRED_S     = 2,
    parameter int unsigned WALK_S       = 8
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic       side_req,
    input  logic       ped_req,
    output logic [2:0] main_lt,
    output logic [2:0] side_lt,
    output logic       walk,
    output logic [2:0] phase,
    output logic [3:0] cnt_tens,
    output logic [3:0] cnt_ones,
    output logic [7:0] HEX1,
    output logic [7:0] HEX0
);

    localparam int unsigned DIV_W = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALL_RED_1   = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        ALL_RED_2   = 3'd5,
        WALK        = 3'd6
    } state_e;

    state_e           state_q, state_d;
    logic [6:0]       count_q, count_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             side_pend_q, side_pend_d;
    logic             tick;
    logic             expire;
    logic             any_pend;
    logic             ped_pend;
    logic [6:0]       rem;
    logic [3:0]       tens;

`ifdef TRAFFIC_PED_EN
    logic ped_pend_q, ped_pend_d;
    assign ped_pend = ped_pend_q;
`else
    logic ped_req_unused;
    localparam int unsigned WALK_S_UNUSED = WALK_S;
    assign ped_req_unused = ped_req;
    assign ped_pend       = 1'b0;
`endif

    assign any_pend = side_pend_q | ped_pend;

    // Duration loaded into the countdown on entry to each state.
    function automatic logic [6:0] dur(input state_e s);
        case (s)
            MAIN_GREEN:  return 7'(MAIN_GREEN_S);
            MAIN_YELLOW: return 7'(YELLOW_S);
            SIDE_GREEN:  return 7'(SIDE_GREEN_S);
            SIDE_YELLOW: return 7'(YELLOW_S);
`ifdef TRAFFIC_PED_EN
            WALK:        return 7'(WALK_S);
`endif
            default:     return 7'(ALLRED_S);
        endcase
    endfunction

    // Active-low segment patterns for one decimal digit.
    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 8'hC0;
            4'd1:    return 8'hF9;
            4'd2:    return 8'hA4;
            4'd3:    return 8'hB0;
            4'd4:    return 8'h99;
            4'd5:    return 8'h92;
            4'd6:    return 8'h82;
            4'd7:    return 8'hF8;
            4'd8:    return 8'h80;
            4'd9:    return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // Tick divider, phase sequencing, countdown and sticky request flags.
    always_comb begin
        tick    = (div_q == DIV_LAST);
        div_d   = tick ? '0 : div_q + DIV_W'(1);
        expire  = tick && (count_q <= 7'd1);
        state_d = state_q;
        count_d = count_q;
        if (tick && (count_q > 7'd1)) begin
            count_d = count_q - 7'd1;
        end
        case (state_q)
            MAIN_GREEN:  if (expire && any_pend) state_d = MAIN_YELLOW;
            MAIN_YELLOW: if (expire) state_d = ALL_RED_1;
            ALL_RED_1:   if (expire) state_d = ped_pend ? WALK : SIDE_GREEN;
`ifdef TRAFFIC_PED_EN
            WALK:        if (expire) state_d = side_pend_q ? SIDE_GREEN : ALL_RED_2;
`endif
            SIDE_GREEN:  if (expire) state_d = SIDE_YELLOW;
            SIDE_YELLOW: if (expire) state_d = ALL_RED_2;
            ALL_RED_2:   if (expire) state_d = MAIN_GREEN;
            default:     state_d = ALL_RED_2;
        endcase
        if (state_d != state_q) begin
            count_d = dur(state_d);
        end
        // A request seen in the clearing cycle survives the clear.
        side_pend_d = side_req |
                      (side_pend_q & ~((state_d == SIDE_GREEN) && (state_q != SIDE_GREEN)));
`ifdef TRAFFIC_PED_EN
        ped_pend_d  = ped_req |
                      (ped_pend_q & ~((state_d == WALK) && (state_q != WALK)));
`endif
    end

    // State register with synchronous reset to the main-green start condition.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state_q     <= MAIN_GREEN;
            count_q     <= 7'(MAIN_GREEN_S);
            div_q       <= '0;
            side_pend_q <= 1'b0;
`ifdef TRAFFIC_PED_EN
            ped_pend_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            div_q       <= div_d;
            side_pend_q <= side_pend_d;
`ifdef TRAFFIC_PED_EN
            ped_pend_q  <= ped_pend_d;
`endif
        end
    end

    // Lamp, walk and phase decode from the registered state.
    always_comb begin
        main_lt = 3'b100;
        side_lt = 3'b100;
        case (state_q)
            MAIN_GREEN:  main_lt = 3'b001;
            MAIN_YELLOW: main_lt = 3'b010;
            SIDE_GREEN:  side_lt = 3'b001;
            SIDE_YELLOW: side_lt = 3'b010;
            default:     ;
        endcase
`ifdef TRAFFIC_PED_EN
        walk = (state_q == WALK);
`else
        walk = 1'b0;
`endif
        phase = state_q;
    end

    // Binary countdown to two BCD digits by repeated subtraction of ten.
    always_comb begin
        rem  = count_q;
        tens = '0;
        for (int unsigned i = 0; i < 9; i++) begin
            if (rem >= 7'd10) begin
                rem  = rem - 7'd10;
                tens = tens + 4'd1;
            end
        end
        cnt_tens = tens;
        cnt_ones = rem[3:0];
    end

    // Seven-segment drive for both countdown digits.
    always_comb begin
        HEX1 = seg7(cnt_tens);
        HEX0 = seg7(cnt_ones);
    end

endmodule

// File: tb/tb_traffic_ctrl_2way.sv
// Testbench for traffic_ctrl_2way: directed scenarios plus random requests,
// all outputs compared every cycle against a phase-schedule reference model.
module tb_traffic_ctrl_2way;

    localparam int unsigned TD = 4;
    localparam int unsigned MG = 5;
    localparam int unsigned SG = 3;
    localparam int unsigned YL = 2;
    localparam int unsigned AR = 1;
    localparam int unsigned WK = 4;

    logic       CLOCK_50 = 1'b0;
    logic       rst      = 1'b1;
    logic       side_req = 1'b0;
    logic       ped_req  = 1'b0;
    logic [2:0] main_lt, side_lt, phase;
    logic       walk;
    logic [3:0] cnt_tens, cnt_ones;
    logic [7:0] HEX1, HEX0;

    traffic_ctrl_2way #(
        .TICK_DIV    (TD),
        .MAIN_GREEN_S(MG),
        .SIDE_GREEN_S(SG),
        .YELLOW_S    (YL),
        .ALLRED_S    (AR),
        .WALK_S      (WK)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .rst     (rst),
        .side_req(side_req),
        .ped_req (ped_req),
        .main_lt (main_lt),
        .side_lt (side_lt),
        .walk    (walk),
        .phase   (phase),
        .cnt_tens(cnt_tens),
        .cnt_ones(cnt_ones),
        .HEX1    (HEX1),
        .HEX0    (HEX0)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Reference model: phase number, ticks remaining, cycle within tick, pending requests.
    int  dur_tbl[7]        = '{MG, YL, AR, SG, YL, AR, WK};
    logic [2:0] main_tbl[7] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] side_tbl[7] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100, 3'b100};
    logic [7:0] seg_tbl[10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    int m_ph, m_cnt, m_div;
    bit m_side, m_ped;

    function automatic int route(input int ph, input bit s, input bit p);
        case (ph)
            0:       return (s || p) ? 1 : 0;
            1:       return 2;
            2:       return p ? 6 : 3;
            6:       return s ? 3 : 5;
            3:       return 4;
            4:       return 5;
            5:       return 0;
            default: return 5;
        endcase
    endfunction

    task automatic model_step(input bit r, input bit s, input bit p);
        int nxt;
        bit tk;
        if (r) begin
            m_ph = 0; m_cnt = MG; m_div = 0; m_side = 0; m_ped = 0;
            return;
        end
        tk    = (m_div == TD - 1);
        m_div = tk ? 0 : m_div + 1;
        nxt   = m_ph;
        if (tk) begin
            if (m_cnt > 1) m_cnt--;
            else nxt = route(m_ph, m_side, m_ped);
        end
        m_side = m_side | s;
`ifdef TRAFFIC_PED_EN
        m_ped  = m_ped | p;
`endif
        if (nxt != m_ph) begin
            m_cnt = dur_tbl[nxt];
            if (nxt == 3) m_side = s;
            if (nxt == 6) m_ped = p;
        end
        m_ph = nxt;
    endtask

    int unsigned seq_q[$];
    logic [2:0]  last_ph;
    bit          side_g_seen;

    task automatic compare_all();
        bit exp_walk;
`ifdef TRAFFIC_PED_EN
        exp_walk = (m_ph == 6);
`else
        exp_walk = 1'b0;
`endif
        check_eq("phase",    phase,    m_ph);
        check_eq("main_lt",  main_lt,  main_tbl[m_ph]);
        check_eq("side_lt",  side_lt,  side_tbl[m_ph]);
        check_eq("walk",     walk,     exp_walk);
        check_eq("cnt_tens", cnt_tens, m_cnt / 10);
        check_eq("cnt_ones", cnt_ones, m_cnt % 10);
        check_eq("HEX1",     HEX1,     seg_tbl[m_cnt / 10]);
        check_eq("HEX0",     HEX0,     seg_tbl[m_cnt % 10]);
    endtask

    task automatic tick_clk();
        @(posedge CLOCK_50);
        model_step(rst, side_req, ped_req);
        #1;
        compare_all();
        if (side_lt === 3'b001) side_g_seen = 1'b1;
        if (phase !== last_ph) begin
            seq_q.push_back(int'(phase));
            last_ph = phase;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; side_req = 1'b0; ped_req = 1'b0;
        repeat (n) tick_clk();
        rst = 1'b0;
        seq_q.delete();
        seq_q.push_back(int'(phase));
        last_ph     = phase;
        side_g_seen = 1'b0;
    endtask

    // Expected phase sequence written as a string of digits.
    task automatic check_seq(input string tag, input string exp_s);
        check_eq({tag, "_len"}, seq_q.size(), exp_s.len());
        for (int i = 0; i < exp_s.len(); i++) begin
            check_eq($sformatf("%s_%0d", tag, i),
                     (i < seq_q.size()) ? seq_q[i] : 32'hFFFF_FFFF,
                     32'(exp_s[i] - 8'h30));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;

        // Reset and idle: main green holds with count stuck at 1.
        do_reset(3);
        check_eq("rst_phase", phase, 3'd0);
        check_eq("rst_main", main_lt, 3'b001);
        check_eq("rst_side", side_lt, 3'b100);
        check_eq("rst_walk", walk, 1'b0);
        check_eq("rst_hex0", HEX0, 8'h92);
        repeat (40 * TD) tick_clk();
        check_eq("idle_hex0", HEX0, 8'hF9);
        check_eq("idle_main", main_lt, 3'b001);
        check_seq("idle_seq", "0");

        // Single side request pulse at tick 2.
        do_reset(3);
        repeat (2 * TD) tick_clk();
        side_req = 1'b1;
        tick_clk();
        side_req = 1'b0;
        repeat (100) tick_clk();
        check_seq("side_seq", "0123450");
        check_eq("side_g_seen", side_g_seen, 1'b1);

        // Pedestrian request only.
        do_reset(3);
`ifdef TRAFFIC_PED_EN
        ped_req = 1'b1;
        tick_clk();
        ped_req = 1'b0;
        repeat (100) tick_clk();
        check_seq("ped_seq", "012650");
        check_eq("ped_no_side_g", side_g_seen, 1'b0);
`else
        ped_req = 1'b1;
        repeat (200) tick_clk();
        ped_req = 1'b0;
        check_seq("ped_ign_seq", "0");
        check_eq("ped_ign_walk", walk, 1'b0);
`endif

        // Reset during side green at count 2, with requests pending.
        do_reset(2);
        side_req = 1'b1;
        tick_clk();
        side_req = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 200 && !hit; k++) begin
            tick_clk();
            side_req = (phase == 3'd3);
            if (phase == 3'd3 && cnt_tens == 4'd0 && cnt_ones == 4'd2) hit = 1'b1;
        end
        check_eq("sg2_found", hit, 1'b1);
        rst = 1'b1; side_req = 1'b1; ped_req = 1'b1;
        tick_clk();
        check_eq("rst_mid_phase", phase, 3'd0);
        check_eq("rst_mid_ones", cnt_ones, 4'd5);
        check_eq("rst_mid_hex0", HEX0, 8'h92);
        check_eq("rst_mid_hex1", HEX1, 8'hC0);
        rst = 1'b0; side_req = 1'b0; ped_req = 1'b0;
        seq_q.delete();
        seq_q.push_back(int'(phase));
        last_ph = phase;
        repeat (120) tick_clk();
        check_seq("rst_clear_seq", "0");

        // Side and pedestrian requests in the same cycle.
        do_reset(3);
        side_req = 1'b1; ped_req = 1'b1;
        tick_clk();
        side_req = 1'b0; ped_req = 1'b0;
        repeat (100) tick_clk();
`ifdef TRAFFIC_PED_EN
        check_seq("both_seq", "01263450");
`else
        check_seq("both_seq", "0123450");
`endif

        // Random requests with occasional resets.
        do_reset(2);
        for (int c = 0; c < 4000; c++) begin
            side_req = ($urandom_range(0, 99) < 3);
            ped_req  = ($urandom_range(0, 99) < 3);
            rst      = ($urandom_range(0, 999) == 0);
            tick_clk();
        end
        rst = 1'b0; side_req = 1'b0; ped_req = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
